// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its skid buffer.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int          PC_WIDTH_DEF     = 32;
  localparam int          INST_WIDTH_DEF   = 32;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  // IF/ID bundle layout: {pc, inst}
  localparam int IFID_WIDTH    = PC_WIDTH_DEF + INST_WIDTH_DEF;
  localparam int IFID_PC_LSB   = 32;
  localparam int IFID_INST_LSB = 0;

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for a fetched {pc, inst} bundle that decode could not accept.
module fetch_skid
  import fetch_pkg::*;
#(
  parameter int WIDTH = IFID_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             full
);

  logic [WIDTH-1:0] dataReg;

  // Only the occupancy flag needs reset; the payload is meaningless while empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load && !clear) begin
      dataReg <= dataIn;
    end
  end

  assign dataOut = dataReg;

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, the instruction-memory handshake and the IF/ID register,
// honouring hazard stalls and EX-stage redirects.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                    PC_WIDTH   = PC_WIDTH_DEF,
  parameter int                    INST_WIDTH = INST_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
  parameter int                    PC_STEP    = 1,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = NOP_INST_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           branch_taken,
  input  logic [PC_WIDTH-1:0]            branch_target,
  output logic                           imem_req,
  output logic [PC_WIDTH-1:0]            imem_addr,
  input  logic                           imem_valid,
  input  logic [INST_WIDTH-1:0]          imem_rdata,
  output logic [PC_WIDTH+INST_WIDTH-1:0] ifid_out,
  output logic                           ifid_valid,
  output logic [PC_WIDTH-1:0]            pc_current
);

  localparam int IfidW = PC_WIDTH + INST_WIDTH;

  fetch_state_t          state, stateNext;
  logic [PC_WIDTH-1:0]   pc, pcNext, pcInc;
  logic [PC_WIDTH-1:0]   drainAddr, drainAddrNext;
  logic [IfidW-1:0]      ifidReg, ifidNext;
  logic                  ifidValidReg, ifidValidNext;
  logic                  skidLoad, skidClear, skidFull;
  logic [IfidW-1:0]      skidData;

  assign pcInc = pc + PC_WIDTH'(PC_STEP);

  fetch_skid #(
    .WIDTH(IfidW)
  ) uSkid (
    .clk    (clk),
    .rst    (rst),
    .load   (skidLoad),
    .clear  (skidClear),
    .dataIn ({pc, imem_rdata}),
    .dataOut(skidData),
    .full   (skidFull)
  );

  always_comb begin
    stateNext     = state;
    pcNext        = pc;
    drainAddrNext = drainAddr;
    ifidNext      = ifidReg;
    ifidValidNext = ifidValidReg;
    skidLoad      = 1'b0;
    skidClear     = 1'b0;

    if (branch_taken) begin
      pcNext        = branch_target;
      ifidNext      = {branch_target, NOP_INST};
      ifidValidNext = 1'b0;
      skidClear     = 1'b0 | 1'b1;
      // A request still in flight must be drained so its wrong-path data is dropped.
      if (state != HOLD && !imem_valid) begin
        stateNext = DRAIN;
      end else begin
        stateNext = FETCH;
      end
      if (state == FETCH && !imem_valid) begin
        drainAddrNext = pc;
      end
    end else begin
      // Consumer took whatever was in IF/ID unless it stalled.
      if (!stall) begin
        ifidValidNext = 1'b0;
      end
      unique case (state)
        FETCH: begin
          if (imem_valid) begin
            pcNext = pcInc;
            if (!stall) begin
              ifidNext      = {pc, imem_rdata};
              ifidValidNext = 1'b1;
            end else begin
              skidLoad  = 1'b1;
              stateNext = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            ifidNext      = skidData;
            ifidValidNext = skidFull;
            skidClear     = 1'b1;
            stateNext     = FETCH;
          end
        end
        DRAIN: begin
          if (imem_valid) begin
            stateNext = FETCH;
          end
        end
        default: stateNext = FETCH;
      endcase
    end
  end

  // IF/ID pipeline boundary and fetch control state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      ifidReg      <= {RESET_PC, NOP_INST};
      ifidValidReg <= 1'b0;
    end else begin
      state        <= stateNext;
      pc           <= pcNext;
      ifidReg      <= ifidNext;
      ifidValidReg <= ifidValidNext;
    end
  end

  always_ff @(posedge clk) begin
    drainAddr <= drainAddrNext;
  end

  assign imem_req   = rst && (state != HOLD);
  assign imem_addr  = (state == DRAIN) ? drainAddr : pc;
  assign ifid_out   = ifidReg;
  assign ifid_valid = ifidValidReg;
  assign pc_current = pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed scenarios followed by randomized
// stall/branch/reset/latency traffic checked against an in-order instruction stream model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [63:0] ifid_out;
  logic        ifid_valid;
  logic [31:0] pc_current;

  int checks     = 0;
  int errors     = 0;
  int deliveries = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instOf(input logic [31:0] a);
    return a + 32'h0000_A000;
  endfunction

  // Instruction memory model with programmable latency (0 = same-cycle answer).
  int          memLat    = 0;
  logic        memBusy   = 1'b0;
  int          memRemain = 0;
  logic [31:0] memAddr   = '0;
  logic        respNow;

  assign respNow    = rst && imem_req && (memBusy ? (memRemain == 0) : (memLat == 0));
  assign imem_valid = respNow;
  assign imem_rdata = respNow ? instOf(imem_addr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (!rst) begin
      memBusy <= 1'b0;
    end else if (imem_req && !respNow) begin
      if (!memBusy) begin
        memBusy   <= 1'b1;
        memRemain <= memLat - 1;
        memAddr   <= imem_addr;
      end else begin
        memRemain <= memRemain - 1;
      end
    end else if (respNow) begin
      memBusy <= 1'b0;
    end
  end

  instruction_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .ifid_out     (ifid_out),
    .ifid_valid   (ifid_valid),
    .pc_current   (pc_current)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected program stream: sequential PCs, restarting at a redirect or reset target.
  logic [63:0] expQ[$];
  logic [31:0] streamPc;

  task automatic refill();
    while (expQ.size() < 8) begin
      expQ.push_back({streamPc, instOf(streamPc)});
      streamPc = streamPc + 32'd1;
    end
  endtask

  task automatic restart(input logic [31:0] t);
    expQ.delete();
    streamPc = t;
    refill();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    refill();
  endtask

  // Monitor: an entry is consumed when valid, not stalled, not flushed, not in reset.
  always @(negedge clk) begin
    if (rst && imem_req && memBusy) begin
      chk("imem_addr_stable", 64'(imem_addr), 64'(memAddr));
    end
    if (rst && ifid_valid && !stall && !branch_taken) begin
      deliveries++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=%h required=none", ifid_out);
      end else begin
        chk("sb_ifid", ifid_out, expQ.pop_front());
      end
    end
  end

  initial begin
    rst           = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    memLat        = 0;
    restart(32'h0);

    // Reset state
    repeat (3) tick();
    chk("rst_req", 64'(imem_req), 64'(0));
    chk("rst_valid", 64'(ifid_valid), 64'(0));
    chk("rst_ifid", ifid_out, 64'h0);
    chk("rst_pc", 64'(pc_current), 64'(0));

    // First fetch, 0-latency memory
    rst = 1'b1;
    #1;
    chk("first_req", 64'(imem_req), 64'(1));
    chk("first_addr", 64'(imem_addr), 64'(0));
    chk("first_valid_pre", 64'(ifid_valid), 64'(0));
    tick();
    chk("first_valid", 64'(ifid_valid), 64'(1));
    chk("first_out", ifid_out, {32'h0, 32'h0000_A000});
    tick();
    chk("seq1_out", ifid_out, {32'h1, 32'h0000_A001});

    // Stall for three edges while pc=2 is fetched
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_out", ifid_out, {32'h1, 32'h0000_A001});
      chk("stall_hold_valid", 64'(ifid_valid), 64'(1));
      chk("stall_hold_req", 64'(imem_req), 64'(0));
    end
    stall = 1'b0;
    tick();
    chk("unstall_skid_out", ifid_out, {32'h2, 32'h0000_A002});
    tick();
    chk("unstall_next_out", ifid_out, {32'h3, 32'h0000_A003});

    // 3-cycle memory, redirect in the second wait cycle
    memLat = 3;
    tick();
    tick();
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    restart(32'h40);
    tick();
    chk("drain_req", 64'(imem_req), 64'(1));
    chk("drain_addr", 64'(imem_addr), 64'(4));
    chk("drain_pc", 64'(pc_current), 64'(32'h40));
    chk("drain_valid", 64'(ifid_valid), 64'(0));
    branch_taken = 1'b0;
    tick();
    chk("redirect_addr", 64'(imem_addr), 64'(32'h40));
    chk("redirect_req", 64'(imem_req), 64'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("redirect_wait_valid", 64'(ifid_valid), 64'(0));
    end
    tick();
    chk("redirect_first_valid", 64'(ifid_valid), 64'(1));
    chk("redirect_first_out", ifid_out, {32'h40, 32'h0000_A040});

    // Branch and stall together with a full skid
    memLat = 0;
    stall  = 1'b1;
    tick();
    chk("skidfull_req", 64'(imem_req), 64'(0));
    chk("skidfull_out", ifid_out, {32'h40, 32'h0000_A040});
    branch_taken  = 1'b1;
    branch_target = 32'h80;
    restart(32'h80);
    tick();
    chk("flush_valid", 64'(ifid_valid), 64'(0));
    chk("flush_out", ifid_out, {32'h80, 32'h0});
    chk("flush_pc", 64'(pc_current), 64'(32'h80));
    chk("flush_req", 64'(imem_req), 64'(1));
    chk("flush_addr", 64'(imem_addr), 64'(32'h80));
    branch_taken = 1'b0;
    stall        = 1'b0;
    tick();
    chk("flush_next_out", ifid_out, {32'h80, 32'h0000_A080});

    // PC wrap at all-ones
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    restart(32'hFFFF_FFFF);
    tick();
    chk("wrap_pc_pre", 64'(pc_current), 64'(32'hFFFF_FFFF));
    chk("wrap_addr_pre", 64'(imem_addr), 64'(32'hFFFF_FFFF));
    branch_taken = 1'b0;
    tick();
    chk("wrap_addr", 64'(imem_addr), 64'(0));
    chk("wrap_pc", 64'(pc_current), 64'(0));
    chk("wrap_out", ifid_out, {32'hFFFF_FFFF, 32'h0000_9FFF});
    tick();
    chk("wrap_next_out", ifid_out, {32'h0, 32'h0000_A000});

    // Reset while draining
    memLat = 3;
    tick();
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    restart(32'h100);
    tick();
    chk("rdrain_addr", 64'(imem_addr), 64'(1));
    chk("rdrain_pc", 64'(pc_current), 64'(32'h100));
    branch_taken = 1'b0;
    rst          = 1'b0;
    restart(32'h0);
    #1;
    chk("rdrain_req_in_rst", 64'(imem_req), 64'(0));
    tick();
    chk("rdrain_pc_after", 64'(pc_current), 64'(0));
    chk("rdrain_valid_after", 64'(ifid_valid), 64'(0));
    chk("rdrain_req_after", 64'(imem_req), 64'(0));
    chk("rdrain_ifid_after", ifid_out, 64'h0);
    memLat = 0;
    rst    = 1'b1;
    #1;
    chk("rdrain_release_req", 64'(imem_req), 64'(1));
    chk("rdrain_release_addr", 64'(imem_addr), 64'(0));

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst          = ($urandom_range(0, 99) != 0);
      stall        = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) begin
        branch_target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      end else begin
        branch_target = 32'($urandom_range(0, 255));
      end
      if (!memBusy && $urandom_range(0, 15) == 0) begin
        memLat = $urandom_range(0, 3);
      end
      if (!rst) begin
        restart(32'h0);
      end else if (branch_taken) begin
        restart(branch_target);
      end
    end
    rst          = 1'b1;
    stall        = 1'b0;
    branch_taken = 1'b0;
    repeat (10) tick();
    chk("deliveries_min", 64'(deliveries > 300), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
